// File: rtl/qdec_pkg.sv
// Shared types and the Gray-step decode for the quadrature decoder.
package qdec_pkg;

  typedef enum logic {S_FILL, S_TRACK} qdec_state_t;

  typedef logic [1:0] qphase_t;

  // Phase encodings as {a, b}; the up (A-leading) order is 00 -> 10 -> 11 -> 01 -> 00.
  localparam qphase_t PH_00 = 2'b00;
  localparam qphase_t PH_10 = 2'b10;
  localparam qphase_t PH_11 = 2'b11;
  localparam qphase_t PH_01 = 2'b01;

  // valid: exactly one phase bit moved; up: that move was forward; illegal: both moved.
  typedef struct packed {
    logic valid;
    logic up;
    logic illegal;
  } qstep_t;

  function automatic qstep_t step_dir(input qphase_t prev, input qphase_t cur);
    qstep_t s;
    s = '0;
    if ((prev ^ cur) == 2'b11) begin
      s.illegal = 1'b1;
    end else if (prev != cur) begin
      s.valid = 1'b1;
      case (prev)
        PH_00:   s.up = (cur == PH_10);
        PH_10:   s.up = (cur == PH_11);
        PH_11:   s.up = (cur == PH_01);
        default: s.up = (cur == PH_00);
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/qdec_sync.sv
// One encoder phase: 2-FF synchronizer, plus a stability filter when
// QDEC_FILTER_EN is defined (a new level must be seen FILT_CYC times in a row).
module qdec_sync
  import qdec_pkg::*;
`ifdef QDEC_FILTER_EN
  #(parameter int FILT_CYC = 4)
`endif
  (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean
);

  logic meta;
  logic sync;

  // Two flops to resolve metastability on the asynchronous pin.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  end

`ifdef QDEC_FILTER_EN
  localparam int FW = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
  localparam logic [FW-1:0] RELOAD = FW'(FILT_CYC - 1);

  logic [FW-1:0] cnt;
  logic          level;

  // Down-counter restarts whenever the sample agrees with the accepted level;
  // terminal count on a disagreeing sample means it has been stable long enough.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      level <= 1'b0;
      cnt   <= RELOAD;
    end else if (sync == level) begin
      cnt <= RELOAD;
    end else if (cnt == '0) begin
      level <= sync;
      cnt   <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign clean = level;
`else
  assign clean = sync;
`endif

endmodule

// File: rtl/quad_decoder_counter.sv
// x4 quadrature decoder feeding an N-bit up/down position counter with
// clear/load, terminal ticks and a saturating illegal-transition counter.
// Optional input filter: define QDEC_FILTER_EN.
//
//   state   | meaning
//   S_FILL  | synchronizer (and filter) refilling after reset; no counting, no err
//   S_TRACK | compare previous phase to current phase every cycle
module quad_decoder_counter
  import qdec_pkg::*;
  #(
  parameter int N        = 8,
  parameter int ERR_W    = 4,
  parameter int FILT_CYC = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             syn_clr,
  input  logic             load,
  input  logic [N-1:0]     d,
  output logic [N-1:0]     q,
  output logic             up_pulse,
  output logic             dn_pulse,
  output logic             dir,
  output logic             max_tick,
  output logic             min_tick,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  // The fill window must cover the synchronizer depth, plus the filter depth
  // when the filter is built in; FILT_CYC has no effect otherwise.
`ifdef QDEC_FILTER_EN
  localparam int FILL_LEN = 2 + FILT_CYC;
`else
  localparam int FILL_LEN = 2 + 0 * FILT_CYC;
`endif
  localparam int              FILL_W      = $clog2(FILL_LEN);
  localparam logic [FILL_W-1:0] FILL_RELOAD = FILL_W'(FILL_LEN - 1);
  localparam logic [N-1:0]      Q_ONE       = N'(1);
  localparam logic [ERR_W-1:0]  ERR_ONE     = ERR_W'(1);

  logic a_s;
  logic b_s;
  qphase_t ab_s;
  qphase_t ab_p;

  qdec_state_t state;
  qdec_state_t state_nxt;
  logic [FILL_W-1:0] fill_cnt;
  logic capture_p;
  qstep_t step;

  qdec_sync
`ifdef QDEC_FILTER_EN
    #(.FILT_CYC(FILT_CYC))
`endif
    u_sync_a (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (a_in),
    .clean (a_s)
  );

  qdec_sync
`ifdef QDEC_FILTER_EN
    #(.FILT_CYC(FILT_CYC))
`endif
    u_sync_b (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (b_in),
    .clean (b_s)
  );

  assign ab_s = {a_s, b_s};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: leave fill at terminal count, then track forever.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL:  if (fill_cnt == '0) state_nxt = S_TRACK;
      S_TRACK: state_nxt = S_TRACK;
      default: state_nxt = S_FILL;
    endcase
  end

  // FSM outputs: when to latch the previous phase and the decoded step.
  always_comb begin
    capture_p = 1'b0;
    step      = '0;
    case (state)
      S_FILL: capture_p = (fill_cnt == '0);
      S_TRACK: begin
        capture_p = 1'b1;
        step      = step_dir(ab_p, ab_s);
      end
      default: begin
        capture_p = 1'b0;
        step      = '0;
      end
    endcase
  end

  // Fill timer counts down while in S_FILL.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fill_cnt <= FILL_RELOAD;
    end else if (state == S_FILL && fill_cnt != '0) begin
      fill_cnt <= fill_cnt - 1'b1;
    end
  end

  // Previous phase follows the current phase every tracked cycle, even when
  // clear/load swallow the step, so a suppressed step is never replayed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ab_p <= PH_00;
    end else if (capture_p) begin
      ab_p <= ab_s;
    end
  end

  // Position counter and step strobes: clear beats load beats step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q        <= '0;
      dir      <= 1'b0;
      up_pulse <= 1'b0;
      dn_pulse <= 1'b0;
    end else begin
      up_pulse <= 1'b0;
      dn_pulse <= 1'b0;
      if (syn_clr) begin
        q <= '0;
      end else if (load) begin
        q <= d;
      end else if (step.valid) begin
        q        <= step.up ? (q + Q_ONE) : (q - Q_ONE);
        dir      <= step.up;
        up_pulse <= step.up;
        dn_pulse <= !step.up;
      end
    end
  end

  // Illegal-jump strobe and its saturating tally; reported regardless of clear/load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      err <= step.illegal;
      if (step.illegal && err_cnt != '1) begin
        err_cnt <= err_cnt + ERR_ONE;
      end
    end
  end

  assign max_tick = (q == '1);
  assign min_tick = (q == '0);

endmodule

// File: tb/tb_quad_decoder_counter.sv
// Directed bench for quad_decoder_counter (N=8, ERR_W=4). Filter scenario
// is only exercised when QDEC_FILTER_EN is defined.
module tb_quad_decoder_counter;

  logic       clk;
  logic       rst_n;
  logic       a_in;
  logic       b_in;
  logic       syn_clr;
  logic       load;
  logic [7:0] d;
  logic [7:0] q;
  logic       up_pulse;
  logic       dn_pulse;
  logic       dir;
  logic       max_tick;
  logic       min_tick;
  logic       err;
  logic [3:0] err_cnt;

`ifdef QDEC_FILTER_EN
  localparam int EXTRA = 4;
`else
  localparam int EXTRA = 0;
`endif
  localparam int FILL_T = 2 + EXTRA;
  localparam int HOLD   = 4 + EXTRA;

  int nvec  = 0;
  int nfail = 0;
  int up_seen;
  int dn_seen;
  int err_seen;

  quad_decoder_counter #(.N(8), .ERR_W(4), .FILT_CYC(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a_in     (a_in),
    .b_in     (b_in),
    .syn_clr  (syn_clr),
    .load     (load),
    .d        (d),
    .q        (q),
    .up_pulse (up_pulse),
    .dn_pulse (dn_pulse),
    .dir      (dir),
    .max_tick (max_tick),
    .min_tick (min_tick),
    .err      (err),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      up_seen  = up_seen + int'(up_pulse);
      dn_seen  = dn_seen + int'(dn_pulse);
      err_seen = err_seen + int'(err);
    end
  endtask

  task automatic clear_seen();
    up_seen  = 0;
    dn_seen  = 0;
    err_seen = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a_in = 1'b0; b_in = 1'b0;
    syn_clr = 1'b0; load = 1'b0; d = 8'h00;
    clear_seen();
    tick(3);
    nvec++; if (q !== 8'h00) begin nfail++; $display("FAIL reset q: got %0h expected 0", q); end
    nvec++; if (dir !== 1'b0) begin nfail++; $display("FAIL reset dir: got %0b expected 0", dir); end
    nvec++; if ({up_pulse, dn_pulse, err} !== 3'b000) begin nfail++; $display("FAIL reset strobes: got %b expected 000", {up_pulse, dn_pulse, err}); end
    nvec++; if (err_cnt !== 4'd0) begin nfail++; $display("FAIL reset err_cnt: got %0d expected 0", err_cnt); end
    nvec++; if ({max_tick, min_tick} !== 2'b01) begin nfail++; $display("FAIL reset ticks: got %b expected 01", {max_tick, min_tick}); end
    rst_n = 1'b1;
    tick(FILL_T);
  endtask

  task automatic test_up_count();
    logic [1:0] seq [4];
    seq = '{2'b10, 2'b11, 2'b01, 2'b00};
    clear_seen();
    {a_in, b_in} = seq[0];
    tick(1 + EXTRA);
    nvec++; if (q !== 8'h00) begin nfail++; $display("FAIL latency q@k: got %0h expected 0", q); end
    tick(1);
    nvec++; if (q !== 8'h00 || up_pulse !== 1'b0) begin nfail++; $display("FAIL latency q@k+1: got q=%0h up=%0b expected q=0 up=0", q, up_pulse); end
    tick(1);
    nvec++; if (q !== 8'h01 || up_pulse !== 1'b1) begin nfail++; $display("FAIL latency q@k+2: got q=%0h up=%0b expected q=1 up=1", q, up_pulse); end
    tick(1);
    nvec++; if (up_pulse !== 1'b0) begin nfail++; $display("FAIL up_pulse width: got %0b expected 0", up_pulse); end
    for (int i = 1; i < 16; i++) begin
      {a_in, b_in} = seq[i % 4];
      tick(HOLD);
    end
    nvec++; if (q !== 8'd16) begin nfail++; $display("FAIL up_count q: got %0d expected 16", q); end
    nvec++; if (up_seen !== 16) begin nfail++; $display("FAIL up_count pulses: got %0d expected 16", up_seen); end
    nvec++; if (dn_seen !== 0 || err_seen !== 0) begin nfail++; $display("FAIL up_count dn/err: got %0d/%0d expected 0/0", dn_seen, err_seen); end
    nvec++; if (dir !== 1'b1) begin nfail++; $display("FAIL up_count dir: got %0b expected 1", dir); end
  endtask

  task automatic test_load_wrap();
    load = 1'b1; d = 8'hFF;
    tick(1);
    load = 1'b0;
    nvec++; if (q !== 8'hFF || max_tick !== 1'b1 || min_tick !== 1'b0) begin nfail++; $display("FAIL load_ff: got q=%0h max=%0b min=%0b expected ff/1/0", q, max_tick, min_tick); end
    clear_seen();
    {a_in, b_in} = 2'b10;
    tick(HOLD);
    nvec++; if (q !== 8'h00 || min_tick !== 1'b1 || max_tick !== 1'b0) begin nfail++; $display("FAIL wrap_up: got q=%0h max=%0b min=%0b expected 0/0/1", q, max_tick, min_tick); end
    nvec++; if (up_seen !== 1) begin nfail++; $display("FAIL wrap_up pulses: got %0d expected 1", up_seen); end
    {a_in, b_in} = 2'b00;
    tick(HOLD);
    nvec++; if (q !== 8'hFF || dir !== 1'b0) begin nfail++; $display("FAIL wrap_dn: got q=%0h dir=%0b expected ff/0", q, dir); end
    nvec++; if (dn_seen !== 1) begin nfail++; $display("FAIL wrap_dn pulses: got %0d expected 1", dn_seen); end
  endtask

  task automatic test_err_sat();
    clear_seen();
    for (int i = 0; i < 3; i++) begin
      {a_in, b_in} = (i % 2 == 0) ? 2'b11 : 2'b00;
      tick(HOLD);
    end
    nvec++; if (err_seen !== 3 || err_cnt !== 4'd3) begin nfail++; $display("FAIL err_three: got strobes=%0d cnt=%0d expected 3/3", err_seen, err_cnt); end
    for (int i = 0; i < 20; i++) begin
      {a_in, b_in} = (i % 2 == 0) ? 2'b00 : 2'b11;
      tick(HOLD);
    end
    nvec++; if (err_seen !== 23) begin nfail++; $display("FAIL err_strobes: got %0d expected 23", err_seen); end
    nvec++; if (err_cnt !== 4'd15) begin nfail++; $display("FAIL err_sat: got %0d expected 15", err_cnt); end
    nvec++; if (q !== 8'hFF || dir !== 1'b0 || up_seen + dn_seen !== 0) begin nfail++; $display("FAIL err_hold: got q=%0h dir=%0b steps=%0d expected ff/0/0", q, dir, up_seen + dn_seen); end
  endtask

  task automatic test_clr_load_priority();
    clear_seen();
    d = 8'h55; syn_clr = 1'b1; load = 1'b1;
    {a_in, b_in} = 2'b01;
    tick(HOLD);
    syn_clr = 1'b0; load = 1'b0;
    nvec++; if (q !== 8'h00 || up_seen + dn_seen !== 0) begin nfail++; $display("FAIL clr_over_load: got q=%0h steps=%0d expected 0/0", q, up_seen + dn_seen); end
    tick(HOLD);
    nvec++; if (q !== 8'h00 || up_seen + dn_seen !== 0) begin nfail++; $display("FAIL step_discarded: got q=%0h steps=%0d expected 0/0", q, up_seen + dn_seen); end
    load = 1'b1;
    {a_in, b_in} = 2'b00;
    tick(HOLD);
    load = 1'b0;
    tick(HOLD);
    nvec++; if (q !== 8'h55 || up_seen + dn_seen !== 0) begin nfail++; $display("FAIL load_over_step: got q=%0h steps=%0d expected 55/0", q, up_seen + dn_seen); end
    nvec++; if (dir !== 1'b0) begin nfail++; $display("FAIL dir_suppressed: got %0b expected 0", dir); end
  endtask

  task automatic test_fill();
    clear_seen();
    rst_n = 1'b0;
    a_in = 1'b1;
    tick(1);
    nvec++; if (q !== 8'h00 || err_cnt !== 4'd0 || dir !== 1'b0) begin nfail++; $display("FAIL midrun_reset: got q=%0h cnt=%0d dir=%0b expected 0/0/0", q, err_cnt, dir); end
    a_in = 1'b0; tick(1);
    a_in = 1'b1; tick(1);
    a_in = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < FILL_T; i++) begin
      #2 a_in = 1'b1;
      #3 a_in = 1'b0;
      tick(1);
    end
    tick(HOLD);
    nvec++; if (q !== 8'h00 || up_seen + dn_seen !== 0 || err_seen !== 0) begin nfail++; $display("FAIL fill_quiet: got q=%0h steps=%0d errs=%0d expected 0/0/0", q, up_seen + dn_seen, err_seen); end
    nvec++; if (err_cnt !== 4'd0) begin nfail++; $display("FAIL fill_err_cnt: got %0d expected 0", err_cnt); end
    a_in = 1'b1;
    tick(HOLD);
    nvec++; if (q !== 8'h01 || up_seen !== 1 || dir !== 1'b1) begin nfail++; $display("FAIL after_fill: got q=%0h ups=%0d dir=%0b expected 1/1/1", q, up_seen, dir); end
  endtask

`ifdef QDEC_FILTER_EN
  task automatic test_filter();
    clear_seen();
    b_in = 1'b1;
    tick(2);
    b_in = 1'b0;
    tick(10);
    nvec++; if (q !== 8'h01 || up_seen + dn_seen + err_seen !== 0) begin nfail++; $display("FAIL filter_glitch: got q=%0h events=%0d expected 1/0", q, up_seen + dn_seen + err_seen); end
    b_in = 1'b1;
    tick(12);
    nvec++; if (q !== 8'h02 || up_seen !== 1) begin nfail++; $display("FAIL filter_level: got q=%0h ups=%0d expected 2/1", q, up_seen); end
  endtask
`endif

  initial begin
    test_reset();
    test_up_count();
    test_load_wrap();
    test_err_sat();
    test_clr_load_priority();
    test_fill();
`ifdef QDEC_FILTER_EN
    test_filter();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
